qpsk_tx_shaper: RTL and testbench

Per-branch transmit pulse shaper for the QPSK link: it accepts one bit per symbol period, maps it to ±1, and drives a polyphase FIR that upsamples by UPSAMPLE and produces one shaped DATA_NBITS sample per clock. It is the transmit counterpart of the per-branch matched-filter receiver. The I and Q branches each use one instance. The output feeds the channel model or DAC path, which in turn feeds the receiver input.

---
 rtl/qpsk_tx_shaper_if.sv | 25 ++
 rtl/qpsk_tx_shaper.sv | 103 ++++++++++
 tb/tb_qpsk_tx_shaper.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/qpsk_tx_shaper_if.sv
// Symbol/sample bus of the QPSK transmit pulse shaper.
// The driver (master) supplies enable and the symbol bit; the shaper (slave)
// returns the symbol request strobe and the shaped output sample.
interface qpsk_tx_shaper_if #(
    parameter int DATA_NBITS = 8
);
    logic                         enable;
    logic                         tx_in;
    logic                         tx_req;
    logic signed [DATA_NBITS-1:0] tx_out;

    modport master (
        output enable,
        output tx_in,
        input  tx_req,
        input  tx_out
    );

    modport slave (
        input  enable,
        input  tx_in,
        output tx_req,
        output tx_out
    );
endinterface

// File: rtl/qpsk_tx_shaper.sv
// Per-branch QPSK transmit pulse shaper.
// Takes one bit per symbol period, maps it to +1/-1 and runs a polyphase FIR
// that upsamples by UPSAMPLE, producing one saturated shaped sample per
// enabled clock. Taps are fixed at elaboration; coef[0] sits in the COEF MSBs.
module qpsk_tx_shaper #(
    parameter int UPSAMPLE   = 4,
    parameter int NCOEF      = 24,
    parameter int COEF_NBITS = 8,
    parameter int COEF_FBITS = 7,
    parameter int DATA_NBITS = 8,
    parameter logic [NCOEF*COEF_NBITS-1:0] COEF = '0
) (
    input  logic             clk,
    input  logic             rst,
    qpsk_tx_shaper_if.slave  bus
);

    localparam int NSYM  = NCOEF / UPSAMPLE;
    localparam int PH_W  = $clog2(UPSAMPLE);
    localparam int ACC_W = COEF_NBITS + $clog2(NSYM) + 1;
    // Working width is never narrower than the output so the in-range slice is legal
    localparam int SUM_W = (ACC_W > DATA_NBITS) ? ACC_W : DATA_NBITS;

    localparam logic [PH_W-1:0]         PH_LAST = PH_W'(UPSAMPLE - 1);
    localparam logic signed [SUM_W-1:0] SAT_HI  = SUM_W'((2 ** (DATA_NBITS - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO  = -SAT_HI - SUM_W'(1);

    // Parameter sanity: power-of-two upsampling, whole symbols of taps, sane Q format
    if (UPSAMPLE < 2 || (UPSAMPLE & (UPSAMPLE - 1)) != 0) begin : g_bad_upsample
        $error("qpsk_tx_shaper: UPSAMPLE must be a power of two and at least 2");
    end
    if ((NCOEF % UPSAMPLE) != 0 || NCOEF < UPSAMPLE) begin : g_bad_ncoef
        $error("qpsk_tx_shaper: NCOEF must be a non-zero multiple of UPSAMPLE");
    end
    if (COEF_FBITS >= COEF_NBITS) begin : g_bad_fbits
        $error("qpsk_tx_shaper: COEF_FBITS must be smaller than COEF_NBITS");
    end

    // Taps rearranged by (symbol slot, phase) so the phase counter indexes directly
    logic signed [COEF_NBITS-1:0] taps [NSYM][UPSAMPLE];

    for (genvar k = 0; k < NSYM; k++) begin : g_sym
        for (genvar p = 0; p < UPSAMPLE; p++) begin : g_ph
            assign taps[k][p] = COEF[COEF_NBITS*NCOEF-1-(k*UPSAMPLE+p)*COEF_NBITS -: COEF_NBITS];
        end
    end

    logic [PH_W-1:0]              phase;
    logic [NSYM-1:0]              sym_valid;
    logic [NSYM-1:0]              sym_pos;
    logic signed [DATA_NBITS-1:0] out_q;
    logic signed [SUM_W-1:0]      acc;
    logic signed [SUM_W-1:0]      tap_ext;
    logic signed [DATA_NBITS-1:0] sat;

    assign bus.tx_req = bus.enable && (phase == PH_LAST);
    assign bus.tx_out = out_q;

    // Polyphase sum of the current phase taps weighted by the stored symbols, then clamp
    always_comb begin
        acc     = '0;
        tap_ext = '0;
        for (int k = 0; k < NSYM; k++) begin
            tap_ext = SUM_W'(taps[k][phase]);
            if (sym_valid[k]) begin
                if (sym_pos[k]) begin
                    acc = acc + tap_ext;
                end else begin
                    acc = acc - tap_ext;
                end
            end
        end
        if (acc > SAT_HI) begin
            sat = SAT_HI[DATA_NBITS-1:0];
        end else if (acc < SAT_LO) begin
            sat = SAT_LO[DATA_NBITS-1:0];
        end else begin
            sat = acc[DATA_NBITS-1:0];
        end
    end

    // Phase count, symbol history shift on the last phase, and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= PH_LAST;
            sym_valid <= '0;
            sym_pos   <= '0;
            out_q     <= '0;
        end else if (bus.enable) begin
            phase <= phase + 1'b1;
            out_q <= sat;
            if (phase == PH_LAST) begin
                for (int k = NSYM - 1; k > 0; k--) begin
                    sym_valid[k] <= sym_valid[k-1];
                    sym_pos[k]   <= sym_pos[k-1];
                end
                sym_valid[0] <= 1'b1;
                sym_pos[0]   <= bus.tx_in;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_tx_shaper.sv
// Directed bench for qpsk_tx_shaper: three instances with different tap sets
// (single tap, ramp, all-max) checked against a direct-form FIR model over
// the zero-stuffed +/-1 symbol stream plus hand-computed key values.
module tb_qpsk_tx_shaper;

    function automatic logic [191:0] rampCoef();
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 24; i++) begin
            r[191-8*i -: 8] = 8'(i + 1);
        end
        return r;
    endfunction

    localparam logic [191:0] COEF_SINGLE = {8'h40, {23{8'h00}}};
    localparam logic [191:0] COEF_RAMP   = rampCoef();
    localparam logic [191:0] COEF_SAT    = {24{8'h7F}};

    logic clk = 1'b0;
    logic rst;

    int testCount = 0;
    int failCount = 0;
    int cnt [3];
    int xs  [3][0:255];
    logic [31:0] gateMask = 32'hB5D3_6E29;

    qpsk_tx_shaper_if #(.DATA_NBITS(8)) busA ();
    qpsk_tx_shaper_if #(.DATA_NBITS(8)) busB ();
    qpsk_tx_shaper_if #(.DATA_NBITS(8)) busC ();

    qpsk_tx_shaper #(.UPSAMPLE(4), .NCOEF(24), .COEF_NBITS(8), .COEF_FBITS(7),
                     .DATA_NBITS(8), .COEF(COEF_SINGLE))
        dutSingle (.clk(clk), .rst(rst), .bus(busA));

    qpsk_tx_shaper #(.UPSAMPLE(4), .NCOEF(24), .COEF_NBITS(8), .COEF_FBITS(7),
                     .DATA_NBITS(8), .COEF(COEF_RAMP))
        dutRamp (.clk(clk), .rst(rst), .bus(busB));

    qpsk_tx_shaper #(.UPSAMPLE(4), .NCOEF(24), .COEF_NBITS(8), .COEF_FBITS(7),
                     .DATA_NBITS(8), .COEF(COEF_SAT))
        dutSat (.clk(clk), .rst(rst), .bus(busC));

    always #5 clk = ~clk;

    function automatic int tapOf(input int d, input int j);
        if (d == 0) return (j == 0) ? 64 : 0;
        if (d == 1) return j + 1;
        return 127;
    endfunction

    // Direct-form FIR over the zero-stuffed stream, sample taken after edge cnt
    function automatic logic [7:0] expVal(input int d);
        int s;
        int t;
        s = 0;
        for (int j = 0; j < 24; j++) begin
            t = cnt[d] - 1 - j;
            if (t >= 1) s += tapOf(d, j) * xs[d][t];
        end
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    function automatic logic [7:0] getOut(input int d);
        case (d)
            0:       return busA.tx_out;
            1:       return busB.tx_out;
            default: return busC.tx_out;
        endcase
    endfunction

    function automatic logic getReq(input int d);
        case (d)
            0:       return busA.tx_req;
            1:       return busB.tx_req;
            default: return busC.tx_req;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        testCount++;
        assert (obs === expv)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic setInputs(input int d, input logic en, input logic b);
        busA.enable = (d == 0) ? en : 1'b0;
        busB.enable = (d == 1) ? en : 1'b0;
        busC.enable = (d == 2) ? en : 1'b0;
        busA.tx_in  = b;
        busB.tx_in  = b;
        busC.tx_in  = b;
    endtask

    task automatic applyStimulus(input int d, input logic en, input logic b);
        logic reqExp;
        setInputs(d, en, b);
        #1;
        reqExp = en && ((cnt[d] % 4) == 0);
        checkOutput($sformatf("dut%0d tx_req c%0d", d, cnt[d]), {7'b0, getReq(d)}, {7'b0, reqExp});
        @(posedge clk);
        #1;
        if (en) begin
            cnt[d]++;
            xs[d][cnt[d]] = ((cnt[d] % 4) == 1) ? (b ? 1 : -1) : 0;
        end
        checkOutput($sformatf("dut%0d tx_out c%0d en%0d", d, cnt[d], en), getOut(d), expVal(d));
    endtask

    initial begin
        int k;
        logic b;
        int steps;

        rst = 1'b0;
        setInputs(0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) cnt[d] = 0;
        #12;
        checkOutput("reset single tx_out", getOut(0), 8'h00);
        checkOutput("reset ramp tx_out", getOut(1), 8'h00);
        checkOutput("reset sat tx_out", getOut(2), 8'h00);
        rst = 1'b1;

        // Single tap: bits 1,0,1 give 0x40/0xC0/0x40 followed by three zeros each
        for (int i = 0; i < 12; i++) begin
            k = cnt[0] / 4;
            b = (k == 1) ? 1'b0 : 1'b1;
            applyStimulus(0, 1'b1, b);
            if (cnt[0] == 2)  checkOutput("single first +1", getOut(0), 8'h40);
            if (cnt[0] == 6)  checkOutput("single -1", getOut(0), 8'hC0);
            if (cnt[0] == 10) checkOutput("single second +1", getOut(0), 8'h40);
        end

        // Impulse walk on ramp taps: one 1 then only 0 bits
        for (int i = 0; i < 28; i++) begin
            b = (cnt[1] == 0);
            applyStimulus(1, 1'b1, b);
            if (cnt[1] >= 2 && cnt[1] <= 5)
                checkOutput($sformatf("ramp impulse c%0d", cnt[1]), getOut(1), 8'(cnt[1] - 1));
        end

        // Saturation: six 1s, six 0s, then alternating 1,0,...
        for (int i = 0; i < 72; i++) begin
            k = cnt[2] / 4;
            b = (k < 6) ? 1'b1 : (k < 12) ? 1'b0 : ((k % 2) == 0);
            applyStimulus(2, 1'b1, b);
            if (cnt[2] == 22) checkOutput("sat positive", getOut(2), 8'h7F);
            if (cnt[2] == 46) checkOutput("sat negative", getOut(2), 8'h80);
            if (cnt[2] == 70) checkOutput("sat mixed zero", getOut(2), 8'h00);
        end

        // Asynchronous reset mid-stream with enable held high
        setInputs(1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset ramp tx_out", getOut(1), 8'h00);
        checkOutput("async reset single tx_out", getOut(0), 8'h00);
        for (int d = 0; d < 3; d++) cnt[d] = 0;
        #2;
        rst = 1'b1;
        applyStimulus(1, 1'b1, 1'b1);

        // Gated enable: same impulse stream, output must follow enabled-edge count only
        steps = 0;
        while (cnt[1] < 28 && steps < 200) begin
            applyStimulus(1, gateMask[steps % 32], 1'b0);
            steps++;
        end
        checkOutput("gated run completed", {7'b0, (cnt[1] >= 28)}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
